// File: rtl/fir_pkg.sv
// Shared definitions for the FIR core: default sizes, ALU op codes and the
// tap sequencer state encoding.
package fir_pkg;

    localparam int DEF_NTAPS   = 16;
    localparam int DEF_DW      = 16;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_ALU_LAT = 2;

    // Operation codes understood by the alu block.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Bus bundle between the tap sequencer and its environment: sample input
// handshake, coefficient write port, ALU operand/result path and output word.
// The slave modport is the sequencer's view, master is the environment's.
interface fir_tap_sequencer_if
    import fir_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) ();

    localparam int AW = $clog2(NTAPS);

    logic                    coef_wr_en;
    logic [AW-1:0]           coef_wr_addr;
    logic signed [DW-1:0]    coef_wr_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DW-1:0]    in_sample;
    logic signed [DW-1:0]    alu_a;
    logic signed [DW-1:0]    alu_b;
    logic [1:0]              alu_op_sel;
    logic signed [ACC_W-1:0] alu_result;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_data;

    modport master (
        output coef_wr_en, coef_wr_addr, coef_wr_data,
        output in_valid, in_sample, alu_result,
        input  in_ready, alu_a, alu_b, alu_op_sel, out_valid, out_data
    );

    modport slave (
        input  coef_wr_en, coef_wr_addr, coef_wr_data,
        input  in_valid, in_sample, alu_result,
        output in_ready, alu_a, alu_b, alu_op_sel, out_valid, out_data
    );

endinterface

// File: rtl/fir_delay_line.sv
// Circular sample buffer. A write stores the sample at the write pointer,
// remembers that slot as the newest (base) and advances the pointer. The read
// port returns x[n-k] = samples[(base - k) mod NTAPS]; NTAPS must be a power
// of two so the modulo is plain pointer wrap.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int DW    = DEF_DW,
    localparam int AW   = $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic signed [DW-1:0] wr_data,
    input  logic [AW-1:0]        rd_k,
    output logic signed [DW-1:0] rd_data
);

    logic signed [DW-1:0] samples_r [NTAPS];
    logic [AW-1:0]        wp_r;
    logic [AW-1:0]        base_r;
    logic [AW-1:0]        rd_idx_s;

    // Sample storage and pointers; clr empties the history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) samples_r[i] <= '0;
            wp_r   <= '0;
            base_r <= '0;
        end else if (clr) begin
            for (int i = 0; i < NTAPS; i++) samples_r[i] <= '0;
            wp_r   <= '0;
            base_r <= '0;
        end else if (wr_en) begin
            samples_r[wp_r] <= wr_data;
            base_r          <= wp_r;
            wp_r            <= wp_r + 1'b1;
        end else begin
            wp_r   <= wp_r;
            base_r <= base_r;
        end
    end

    // Combinational read of the k-th most recent sample.
    always_comb begin
        rd_idx_s = base_r - rd_k;
        rd_data  = samples_r[rd_idx_s];
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accepts one sample at a time, issues NTAPS signed
// multiplies to the downstream ALU, accumulates the products that return
// ALU_LAT cycles later and emits one filtered word per sample.
// ALU operands are registered, so the operands for tap 0 are loaded on the
// acceptance edge straight from in_sample (bypassing the delay line write).
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS   = DEF_NTAPS,
    parameter int DW      = DEF_DW,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int ALU_LAT = DEF_ALU_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    fir_tap_sequencer_if.slave    bus
);

    localparam int AW  = $clog2(NTAPS);
    localparam int DCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t                  state_r;
    logic [AW-1:0]           tap_r;
    logic [DCW-1:0]          drain_r;
    logic signed [DW-1:0]    coef_r [NTAPS];
    logic signed [ACC_W-1:0] acc_r;
    logic [ALU_LAT-1:0]      pipe_r;
    logic                    in_ready_r;
    logic                    busy_r;
    logic signed [DW-1:0]    alu_a_r;
    logic signed [DW-1:0]    alu_b_r;
    logic [1:0]              op_r;
    logic                    out_valid_r;
    logic signed [ACC_W-1:0] out_data_r;

    logic                    accept_s;
    logic                    coef_we_s;
    logic signed [DW-1:0]    coef0_s;
    logic [AW-1:0]           next_tap_s;
    logic signed [DW-1:0]    rd_data_s;
    logic                    issuing_s;
    logic signed [ACC_W-1:0] acc_next_s;

    fir_delay_line #(
        .NTAPS (NTAPS),
        .DW    (DW)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (accept_s),
        .wr_data (bus.in_sample),
        .rd_k    (next_tap_s),
        .rd_data (rd_data_s)
    );

    // Handshake decode and tap-0 coefficient forwarding for a same-cycle write.
    always_comb begin
        accept_s   = bus.in_valid & in_ready_r & ~clr;
        coef_we_s  = bus.coef_wr_en & (state_r == IDLE);
        next_tap_s = tap_r + 1'b1;
        issuing_s  = (op_r == OP_MUL);
        if (coef_we_s && (bus.coef_wr_addr == '0)) begin
            coef0_s = bus.coef_wr_data;
        end else begin
            coef0_s = coef_r[0];
        end
    end

    // Next accumulator value: add the product that is returning this cycle.
    always_comb begin
        if (pipe_r[ALU_LAT-1]) begin
            acc_next_s = acc_r + bus.alu_result;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Coefficient register file; writable only while idle, kept across clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) coef_r[i] <= '0;
        end else if (coef_we_s) begin
            coef_r[bus.coef_wr_addr] <= bus.coef_wr_data;
        end else begin
            coef_r[0] <= coef_r[0];
        end
    end

    // Product-return tracker and accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_r <= '0;
            acc_r  <= '0;
        end else if (clr) begin
            pipe_r <= '0;
            acc_r  <= '0;
        end else if (accept_s) begin
            pipe_r <= (pipe_r << 1) | ALU_LAT'(issuing_s);
            acc_r  <= '0;
        end else begin
            pipe_r <= (pipe_r << 1) | ALU_LAT'(issuing_s);
            acc_r  <= acc_next_s;
        end
    end

    // Control FSM with registered handshake, ALU operand and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            tap_r       <= '0;
            drain_r     <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            op_r        <= OP_ADD;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (clr) begin
            state_r     <= IDLE;
            tap_r       <= '0;
            drain_r     <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            op_r        <= OP_ADD;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (accept_s) begin
                        state_r    <= ISSUE;
                        tap_r      <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        alu_a_r    <= bus.in_sample;
                        alu_b_r    <= coef0_s;
                        op_r       <= OP_MUL;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ISSUE: begin
                    if (tap_r == AW'(NTAPS - 1)) begin
                        state_r <= DRAIN;
                        drain_r <= '0;
                        alu_a_r <= '0;
                        alu_b_r <= '0;
                        op_r    <= OP_ADD;
                    end else begin
                        tap_r   <= next_tap_s;
                        alu_a_r <= rd_data_s;
                        alu_b_r <= coef_r[next_tap_s];
                        op_r    <= OP_MUL;
                    end
                end
                DRAIN: begin
                    if (drain_r == DCW'(ALU_LAT - 1)) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        out_data_r  <= acc_next_s;
                    end else begin
                        drain_r     <= drain_r + 1'b1;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    alu_a_r     <= '0;
                    alu_b_r     <= '0;
                    op_r        <= OP_ADD;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_op_sel = op_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer paired with a 2-cycle multiply model.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic busy;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic signed [31:0] exp_q [$];
    logic signed [31:0] p1;

    fir_tap_sequencer_if bus ();

    fir_tap_sequencer dut (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter (number of rising edges so far).
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: signed multiply, two-cycle latency.
    always @(posedge clk) begin
        p1             <= bus.alu_a * bus.alu_b;
        bus.alu_result <= p1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 0, 1);
    endtask

    task automatic wr_coef(input int a, input int d);
        @(negedge clk);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = 4'(a);
        bus.coef_wr_data = 16'(d);
        @(negedge clk);
        bus.coef_wr_en   = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Present a sample (optionally with a coefficient write in the same cycle)
    // and return at the falling edge of ISSUE cycle 0.
    task automatic send(input int s, input bit wr, input int wa, input int wd);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'(s);
        if (wr) begin
            bus.coef_wr_en   = 1'b1;
            bus.coef_wr_addr = 4'(wa);
            bus.coef_wr_data = 16'(wd);
        end
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        accept_cyc = cyc + 1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.coef_wr_en = 1'b0;
    endtask

    initial begin
        logic signed [31:0] e;
        int mul;
        int bad;
        int n;

        rst = 1'b0;
        clr = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_sample    = '0;
        bus.coef_wr_en   = 1'b0;
        bus.coef_wr_addr = '0;
        bus.coef_wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_op_sel", bus.alu_op_sel, 0);
        rst = 1'b1;

        // Monitor: pop and compare whenever the DUT presents an output.
        fork
            forever begin
                logic signed [31:0] x;
                @(negedge clk);
                if (bus.out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: got out_valid=1 data=%0d, required no output",
                                 bus.out_data);
                    end else begin
                        x = exp_q.pop_front();
                        check("out_data", bus.out_data, x);
                        check("latency", cyc - accept_cyc, 18);
                    end
                end
            end
        join_none

        // Impulse response with coef[k] = k+1.
        for (int k = 0; k < 16; k++) wr_coef(k, k + 1);
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back((i < 16) ? 32'(i + 1) : 32'sd0);
            send((i == 0) ? 1 : 0, 1'b0, 0, 0);
        end

        // Steady state and write-pointer wrap: all-ones filter, 32 ones.
        wait_idle();
        do_clr();
        for (int k = 0; k < 16; k++) wr_coef(k, 1);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back((i < 16) ? 32'(i + 1) : 32'sd16);
            send(1, 1'b0, 0, 0);
        end

        // Signed extreme: (-32768) * (-32768) on tap 0.
        wait_idle();
        do_clr();
        wr_coef(0, -32768);
        for (int k = 1; k < 16; k++) wr_coef(k, 0);
        exp_q.push_back(32'sd1073741824);
        send(-32768, 1'b0, 0, 0);
        check("tap0_alu_a", bus.alu_a, -32768);
        check("tap0_alu_b", bus.alu_b, -32768);
        mul = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.alu_op_sel == 2'b01) mul++;
            else if (bus.alu_op_sel != 2'b00) bad++;
            @(negedge clk);
        end
        check("mul_cycles", mul, 16);
        check("bad_op_sel", bad, 0);

        // Accumulator wrap: sixteen 32767 * 32767 terms.
        wait_idle();
        do_clr();
        for (int k = 0; k < 16; k++) wr_coef(k, 32767);
        e = 32'sd0;
        for (int i = 0; i < 16; i++) begin
            e = e + 32'sd1073676289;
            exp_q.push_back((i == 15) ? -32'sd1048560 : e);
            send(32767, 1'b0, 0, 0);
        end

        // Coefficient write while busy is ignored; with acceptance it is used.
        wait_idle();
        do_clr();
        for (int k = 0; k < 16; k++) wr_coef(k, (k == 0) ? 2 : 0);
        exp_q.push_back(32'sd6);
        send(3, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = 4'd0;
        bus.coef_wr_data = 16'sd5;
        @(negedge clk);
        bus.coef_wr_en   = 1'b0;
        exp_q.push_back(32'sd5);
        send(1, 1'b1, 0, 5);

        // Reset during ISSUE cycle 7: no output, clean restart.
        wait_idle();
        for (int k = 0; k < 16; k++) wr_coef(k, k + 1);
        send(7, 1'b0, 0, 0);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_busy", busy, 0);
        for (int k = 0; k < 16; k++) wr_coef(k, k + 1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(i + 1));
            send((i == 0) ? 1 : 0, 1'b0, 0, 0);
        end

        // clr during DRAIN: no output, delay line zeroed, coefficients kept.
        wait_idle();
        send(9, 1'b0, 0, 0);
        repeat (16) @(negedge clk);
        check("drain_busy", busy, 1);
        check("drain_in_ready", bus.in_ready, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(i + 1));
            send((i == 0) ? 1 : 0, 1'b0, 0, 0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pending_outputs", exp_q.size(), 0);
        repeat (25) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
